// File: rtl/vga_fb_arbiter.sv
// VGA scan generator and single-port frame-buffer arbiter.
// Display reads own every active-video cycle; CPU-side writes are slotted into
// blanking cycles through a small handshake FSM. Pixel, blank and sync outputs
// leave through a two-stage pipeline so they stay aligned with the RAM read.
module vga_fb_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 15
) (
  input  logic              PIXELCLK,
  input  logic              RST,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic              o_fb_we,
  output logic [DATA_W-1:0] o_fb_wdata,
  input  logic [DATA_W-1:0] i_fb_rdata,
  output logic              o_w_en,
  output logic [DATA_W-1:0] o_data,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);

  localparam logic [HC_W-1:0]   H_LAST  = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0]   V_LAST  = VC_W'(V_TOTAL - 1);
  localparam logic [HC_W-1:0]   H_ACT_C = HC_W'(H_ACTIVE);
  localparam logic [VC_W-1:0]   V_ACT_C = VC_W'(V_ACTIVE);
  localparam logic [HC_W-1:0]   HS_BEG  = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0]   HS_END  = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0]   VS_BEG  = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0]   VS_END  = VC_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_ACK} wr_state_t;

  logic [HC_W-1:0] hcnt;
  logic [VC_W-1:0] vcnt;
  wr_state_t       wr_state;
  logic            disp;
  logic            hs_act;
  logic            vs_act;
  logic            wr_grant;
  logic            addr_ok;
  logic            vld_p0;
  logic            hs_p0;
  logic            vs_p0;
  logic            fs_p0;

  // One frame-buffer cell covers a 4x4 block of screen pixels.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [HC_W-1:0] h,
                                                  input logic [VC_W-1:0] v);
    logic [31:0] a;
    a = (32'(v) >> 2) * FB_W + (32'(h) >> 2);
    return ADDR_W'(a);
  endfunction

  assign disp   = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
  assign hs_act = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_act = (vcnt >= VS_BEG) && (vcnt < VS_END);
  assign addr_ok = (i_wr_addr < FB_SIZE);
  // A write may only take the port in a blanking cycle and never right after an ack.
  assign wr_grant = i_wr_req && !disp && (wr_state != W_ACK);

  // Raster counters: hcnt walks a line, vcnt advances on each line wrap.
  always_ff @(posedge PIXELCLK or posedge RST) begin
    if (RST) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VC_W'(1);
    end else begin
      hcnt <= hcnt + HC_W'(1);
    end
  end

  // Write handshake: park in W_WAIT during active video, hold off one cycle after an ack.
  always_ff @(posedge PIXELCLK or posedge RST) begin
    if (RST) begin
      wr_state <= W_IDLE;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (wr_grant)      wr_state <= W_ACK;
          else if (i_wr_req) wr_state <= W_WAIT;
        end
        W_WAIT: begin
          if (!i_wr_req)     wr_state <= W_IDLE;
          else if (wr_grant) wr_state <= W_ACK;
        end
        W_ACK:   wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // RAM port mux: the grant lands in the same cycle as the slot, so these decode combinationally.
  always_comb begin
    o_wr_ack   = wr_grant;
    o_fb_we    = wr_grant && addr_ok;
    o_fb_addr  = '0;
    o_fb_wdata = '0;
    if (disp)          o_fb_addr = cell_addr(hcnt, vcnt);
    else if (wr_grant) o_fb_addr = i_wr_addr;
    if (o_fb_we)       o_fb_wdata = i_wr_data;
  end

  // Stage p0: timing flags of the cycle that issued the read address.
  always_ff @(posedge PIXELCLK or posedge RST) begin
    if (RST) begin
      vld_p0 <= 1'b0;
      hs_p0  <= 1'b1;
      vs_p0  <= 1'b1;
      fs_p0  <= 1'b0;
    end else begin
      vld_p0 <= disp;
      hs_p0  <= !hs_act;
      vs_p0  <= !vs_act;
      fs_p0  <= (hcnt == '0) && (vcnt == '0);
    end
  end

  // Stage p1: RAM data arrives now; register it with its flags, zeroed while blanked.
  always_ff @(posedge PIXELCLK or posedge RST) begin
    if (RST) begin
      o_w_en        <= 1'b1;
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_frame_start <= 1'b0;
      o_data        <= '0;
    end else begin
      o_w_en        <= !vld_p0;
      o_hsync       <= hs_p0;
      o_vsync       <= vs_p0;
      o_frame_start <= fs_p0;
      o_data        <= vld_p0 ? i_fb_rdata : '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter using a reduced raster (80x38 total, 64x32 active,
// 16x8 frame buffer) so several frames fit in a short run. A behavioural RAM
// sits on the frame-buffer port; a raster-position model predicts every output.
module tb_vga_fb_arbiter;

  localparam int TH_ACT = 64, TH_FP = 4, TH_SYNC = 8, TH_BP = 4;
  localparam int TV_ACT = 32, TV_FP = 2, TV_SYNC = 2, TV_BP = 2;
  localparam int TFB_W = 16, TFB_H = 8;
  localparam int HT = TH_ACT + TH_FP + TH_SYNC + TH_BP;
  localparam int VT = TV_ACT + TV_FP + TV_SYNC + TV_BP;
  localparam int F = HT * VT;
  localparam int LIM = TFB_W * TFB_H;
  localparam int HS_B = TH_ACT + TH_FP, HS_E = TH_ACT + TH_FP + TH_SYNC;
  localparam int VS_B = TV_ACT + TV_FP, VS_E = TV_ACT + TV_FP + TV_SYNC;

  logic        PIXELCLK = 1'b0;
  logic        RST;
  logic        i_wr_req;
  logic [14:0] i_wr_addr;
  logic [7:0]  i_wr_data;
  logic        o_wr_ack;
  logic [14:0] o_fb_addr;
  logic        o_fb_we;
  logic [7:0]  o_fb_wdata;
  logic [7:0]  i_fb_rdata;
  logic        o_w_en;
  logic [7:0]  o_data;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_frame_start;

  vga_fb_arbiter #(
    .H_ACTIVE(TH_ACT), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
    .V_ACTIVE(TV_ACT), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
    .FB_W(TFB_W), .FB_H(TFB_H), .DATA_W(8), .ADDR_W(15)
  ) dut (
    .PIXELCLK(PIXELCLK), .RST(RST),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_ack(o_wr_ack), .o_fb_addr(o_fb_addr), .o_fb_we(o_fb_we),
    .o_fb_wdata(o_fb_wdata), .i_fb_rdata(i_fb_rdata), .o_w_en(o_w_en),
    .o_data(o_data), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_frame_start(o_frame_start)
  );

  always #5 PIXELCLK = ~PIXELCLK;

  // Synchronous single-port RAM: read data valid one cycle after the address.
  logic [7:0] ram [0:511];
  bit         ram_ready = 1'b0;
  always @(posedge PIXELCLK) begin
    if (!ram_ready) begin
      for (int i = 0; i < 512; i++) ram[i] <= 8'((i * 37 + 11) & 255);
      ram_ready <= 1'b1;
    end else if (o_fb_we) begin
      ram[o_fb_addr[8:0]] <= o_fb_wdata;
    end
    i_fb_rdata <= ram[o_fb_addr[8:0]];
  end

  typedef struct packed {
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] d;
  } pix_t;

  logic [7:0] fbm [0:511];
  pix_t       pq[$];
  int         ack_q[$];
  int         k;
  bit         cool;
  bit         ack_seen;
  bit         we_seen;
  bit         rnd_mode;
  bit         fs_seen;
  int         last_fs;
  int         hs_lo, vs_lo, unbl;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic check_reset(input string t);
    chk({t, "_fb_we"},    32'(o_fb_we),       32'(0));
    chk({t, "_wr_ack"},   32'(o_wr_ack),      32'(0));
    chk({t, "_fb_addr"},  32'(o_fb_addr),     32'(0));
    chk({t, "_fb_wdata"}, 32'(o_fb_wdata),    32'(0));
    chk({t, "_data"},     32'(o_data),        32'(0));
    chk({t, "_w_en"},     32'(o_w_en),        32'(1));
    chk({t, "_hsync"},    32'(o_hsync),       32'(1));
    chk({t, "_vsync"},    32'(o_vsync),       32'(1));
    chk({t, "_fstart"},   32'(o_frame_start), 32'(0));
  endtask

  task automatic model_reset();
    k = 0;
    cool = 1'b0;
    ack_seen = 1'b0;
    fs_seen = 1'b0;
    pq.delete();
    hs_lo = 0;
    vs_lo = 0;
    unbl = 0;
  endtask

  // Predict and compare one clock cycle from its position in the raster.
  task automatic model_cycle();
    int         p, h, v;
    logic [8:0] ca;
    bit         disp, exp_ack, exp_we;
    pix_t       e, o;
    p = k % F;
    h = p % HT;
    v = p / HT;
    disp = (h < TH_ACT) && (v < TV_ACT);
    ca = 9'((v / 4) * TFB_W + h / 4);
    exp_ack = i_wr_req && !cool && !disp;
    exp_we = exp_ack && (32'(i_wr_addr) < LIM);
    chk("wr_ack", 32'(o_wr_ack), 32'(exp_ack));
    chk("fb_we", 32'(o_fb_we), 32'(exp_we));
    if (disp) chk("rd_addr", 32'(o_fb_addr), 32'(ca));
    if (exp_we) begin
      chk("wr_addr", 32'(o_fb_addr), 32'(i_wr_addr));
      chk("wr_data", 32'(o_fb_wdata), 32'(i_wr_data));
      fbm[i_wr_addr[8:0]] = i_wr_data;
    end
    cool = exp_ack;
    if (o_wr_ack) ack_q.push_back(k);
    if (o_fb_we) we_seen = 1'b1;
    ack_seen = o_wr_ack;

    e.blank = !disp;
    e.hs = !((h >= HS_B) && (h < HS_E));
    e.vs = !((v >= VS_B) && (v < VS_E));
    e.fs = (p == 0);
    e.d = disp ? fbm[ca] : 8'h00;
    pq.push_back(e);
    if (k >= 2) o = pq.pop_front();
    else        o = '{blank: 1'b1, hs: 1'b1, vs: 1'b1, fs: 1'b0, d: 8'h00};
    chk("w_en",   32'(o_w_en),        32'(o.blank));
    chk("hsync",  32'(o_hsync),       32'(o.hs));
    chk("vsync",  32'(o_vsync),       32'(o.vs));
    chk("fstart", 32'(o_frame_start), 32'(o.fs));
    chk("data",   32'(o_data),        32'(o.d));

    if (o_frame_start) begin
      if (fs_seen) begin
        chk("frame_period", 32'(k - last_fs), 32'(F));
        chk("hs_low_per_frame", 32'(hs_lo), 32'(TH_SYNC * VT));
        chk("vs_low_per_frame", 32'(vs_lo), 32'(TV_SYNC * HT));
        chk("unblank_per_frame", 32'(unbl), 32'(TH_ACT * TV_ACT));
      end else begin
        chk("first_fstart", 32'(k), 32'(2));
      end
      fs_seen = 1'b1;
      last_fs = k;
      hs_lo = 0;
      vs_lo = 0;
      unbl = 0;
    end
    if (!o_hsync) hs_lo++;
    if (!o_vsync) vs_lo++;
    if (!o_w_en)  unbl++;
    k++;
  endtask

  task automatic new_req_fields();
    if ($urandom_range(7) == 0) i_wr_addr = 15'(LIM + $urandom_range(200));
    else                        i_wr_addr = 15'($urandom_range(LIM - 1));
    i_wr_data = 8'($urandom_range(255));
  endtask

  task automatic drive_random();
    if (i_wr_req) begin
      if (ack_seen) begin
        if ($urandom_range(3) == 0) new_req_fields();
        else i_wr_req = 1'b0;
      end else if ($urandom_range(47) == 0) begin
        i_wr_req = 1'b0;
      end
    end else if ($urandom_range(29) == 0) begin
      i_wr_req = 1'b1;
      new_req_fields();
    end
  endtask

  task automatic step();
    @(negedge PIXELCLK);
    model_cycle();
    @(posedge PIXELCLK);
    #1;
    if (rnd_mode) drive_random();
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  initial begin
    int         tgt;
    logic [7:0] saved;
    for (int i = 0; i < 512; i++) fbm[i] = 8'((i * 37 + 11) & 255);
    RST = 1'b1;
    i_wr_req = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;
    rnd_mode = 1'b0;
    we_seen = 1'b0;
    k = 0;
    repeat (3) @(posedge PIXELCLK);
    #1;
    check_reset("por");
    RST = 1'b0;
    model_reset();

    // Request during active video waits for the first blanking cycle of the line.
    run_to(2 * HT + 20);
    i_wr_req = 1'b1; i_wr_addr = 15'h0005; i_wr_data = 8'hAB;
    ack_q.delete();
    for (int i = 0; i < 200 && !ack_seen; i++) step();
    if (ack_q.size() > 0) chk("wait_ack_pos", 32'(ack_q[0]), 32'(2 * HT + TH_ACT));
    else                  chk("wait_ack_timeout", 32'(0), 32'(1));
    i_wr_req = 1'b0;
    step();
    chk("wait_ram_written", 32'(ram[5]), 32'(8'hAB));

    // Request in blanking is acked at once; a held request is acked again two cycles on.
    run_to(20 * HT + 70);
    i_wr_req = 1'b1; i_wr_addr = 15'd10; i_wr_data = 8'h5A;
    ack_q.delete();
    step();
    i_wr_addr = 15'd11; i_wr_data = 8'h5B;
    repeat (3) step();
    i_wr_req = 1'b0;
    if (ack_q.size() >= 2) begin
      chk("b2b_first_ack", 32'(ack_q[0]), 32'(20 * HT + 70));
      chk("b2b_second_ack", 32'(ack_q[1]), 32'(20 * HT + 72));
    end else begin
      chk("b2b_ack_count", 32'(ack_q.size()), 32'(2));
    end

    // Out-of-range address: acked, never written.
    run_to(22 * HT + 66);
    saved = ram[LIM];
    we_seen = 1'b0;
    i_wr_req = 1'b1; i_wr_addr = 15'(LIM); i_wr_data = 8'h77;
    ack_q.delete();
    for (int i = 0; i < 20 && !ack_seen; i++) step();
    i_wr_req = 1'b0;
    repeat (2) step();
    chk("oob_ack_count", 32'(ack_q.size()), 32'(1));
    chk("oob_we_seen", 32'(we_seen), 32'(0));
    chk("oob_ram_kept", 32'(ram[LIM]), 32'(saved));

    // Request withdrawn while waiting: no ack, no write.
    run_to(25 * HT + 10);
    saved = ram[3];
    i_wr_req = 1'b1; i_wr_addr = 15'd3; i_wr_data = 8'h11;
    ack_q.delete();
    run_to(25 * HT + 30);
    i_wr_req = 1'b0;
    repeat (60) step();
    chk("abort_ack_count", 32'(ack_q.size()), 32'(0));
    chk("abort_ram_kept", 32'(ram[3]), 32'(saved));

    // Random traffic over several frames.
    rnd_mode = 1'b1;
    repeat (4 * F) step();
    rnd_mode = 1'b0;
    i_wr_req = 1'b0;

    // Asynchronous reset while a request is parked during active video.
    tgt = (k / F + 1) * F + 24 * HT + 30;
    run_to(tgt);
    i_wr_req = 1'b1;
    i_wr_addr = 15'($urandom_range(LIM - 1));
    i_wr_data = 8'($urandom_range(255));
    saved = ram[i_wr_addr[8:0]];
    repeat (10) step();
    #2;
    RST = 1'b1;
    #1;
    check_reset("rst_async");
    repeat (2) @(posedge PIXELCLK);
    #1;
    check_reset("rst_hold");
    chk("rst_ram_kept", 32'(ram[i_wr_addr[8:0]]), 32'(saved));
    RST = 1'b0;
    i_wr_req = 1'b0;
    model_reset();

    rnd_mode = 1'b1;
    repeat (2 * F + 50) step();
    rnd_mode = 1'b0;
    i_wr_req = 1'b0;
    repeat (3) step();
    for (int i = 0; i < LIM + 64; i++) chk("ram_final", 32'(ram[i]), 32'(fbm[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameters SHALL be: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, FB_W 160, FB_H 120 (one frame-buffer cell per 4x4 screen pixels).
REQ-002 PIXELCLK  in  1  sole clock; all flops rising-edge.
REQ-003 RST  in  1  reset; one clock, reset asynchronous and active-high.
REQ-004 i_wr_req  in  1  write request; held high, addr/data stable, until o_wr_ack.
REQ-005 i_wr_addr  in  15  frame-buffer write address.
REQ-006 i_wr_data  in  8  grayscale write data.
REQ-007 o_wr_ack  out  1  one-cycle pulse; request serviced.
REQ-008 o_fb_addr  out  15  single-port RAM address.
REQ-009 o_fb_we  out  1  RAM write strobe.
REQ-010 o_fb_wdata  out  8  RAM write data.
REQ-011 i_fb_rdata  in  8  RAM read data, valid 1 cycle after o_fb_addr.
REQ-012 o_w_en  out  1  blank flag to VGA output stage; 1 = force pixel to 0.
REQ-013 o_data  out  8  grayscale pixel to VGA output stage.
REQ-014 o_hsync, o_vsync  out  1 each  active-low sync.
REQ-015 o_frame_start  out  1  one-cycle pulse at first active pixel of a frame.

Function
REQ-016 hcnt SHALL count 0..799 and wrap to 0; vcnt SHALL increment on hcnt wrap, counting 0..524 then wrapping to 0.
REQ-017 Display slot: hcnt<640 and vcnt<480; all other counter positions SHALL be write slots.
REQ-018 In a display slot, o_fb_addr SHALL be (vcnt>>2)*160 + (hcnt>>2), o_fb_we 0.
REQ-019 Display reads SHALL have absolute priority; no write SHALL occur in a display slot.
REQ-020 Write FSM SHALL have states W_IDLE, W_WAIT, W_ACK.
REQ-021 W_IDLE: i_wr_req=1 and write slot -> drive o_fb_addr=i_wr_addr, o_fb_wdata=i_wr_data, o_fb_we=1, o_wr_ack=1 same cycle, go W_ACK; i_wr_req=1 in display slot -> W_WAIT.
REQ-022 W_WAIT: first write slot -> perform write and ack as in REQ-021, go W_ACK.
REQ-023 W_ACK: SHALL last exactly one cycle, no write, return to W_IDLE (max one write per two cycles; a request held after ack is a new request).
REQ-024 i_wr_addr >= 19200: o_wr_ack SHALL still pulse, o_fb_we SHALL stay 0 (write dropped).
REQ-025 i_wr_req deasserted in W_WAIT SHALL return FSM to W_IDLE with no write and no ack.
REQ-026 Pixel path: counter cycle N issues address; i_fb_rdata captured cycle N+1; o_data/o_w_en registered at N+2.
REQ-027 o_hsync (low for hcnt 656..751), o_vsync (low for vcnt 490..491), o_w_en (1 outside display slot) and o_frame_start (hcnt=0,vcnt=0) SHALL be delayed 2 cycles to align with o_data.
REQ-028 o_data SHALL be 0 whenever o_w_en=1.
REQ-029 A write and a display read to the same address in different cycles SHALL not be reordered: read in the following frame returns new data.

Reset
REQ-030 RST=1 SHALL immediately force: hcnt=vcnt=0, FSM W_IDLE, o_fb_we 0, o_wr_ack 0, o_fb_addr 0, o_fb_wdata 0, o_data 0, o_w_en 1, o_hsync 1, o_vsync 1, o_frame_start 0, delay pipeline cleared to blank.
REQ-031 RST asserted mid-write SHALL abort it without ack; requester must re-request.
REQ-032 After RST release, first o_frame_start SHALL occur 2 cycles after the first rising edge.

Verification
REQ-033 Free-run 2 frames, no writes -> o_frame_start period 420000 cycles; hsync low 96 cycles/line; vsync low 1600 cycles/frame; 307200 unblanked pixels/frame.
REQ-034 Write req at hcnt=100,vcnt=10 addr 0x0005 data 0xAB -> ack at hcnt=640,vcnt=10 with o_fb_we=1; next frame pixels hcnt 20..23, vcnt 0..3 show 0xAB.
REQ-035 Write req at hcnt=700,vcnt=200 -> o_fb_we and o_wr_ack same cycle; held req -> second ack exactly 2 cycles later.
REQ-036 Write addr 19200 -> ack pulse, o_fb_we never 1, RAM unchanged.
REQ-037 Req in W_WAIT dropped at hcnt=300 -> no ack, no write, FSM W_IDLE.
REQ-038 RST pulse at hcnt=400,vcnt=300 during pending write -> all outputs to REQ-030 values asynchronously; no ack; timing restarts at hcnt=0,vcnt=0.
